// File: rtl/mips_dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, the CPU data port, the
// debug/bench access port and the data RAM.
//
// Debug handshake: the requester raises dbg_req with dbg_write, dbg_address
// and dbg_writedata stable and holds them until dbg_ack. dbg_ack is a
// one-cycle pulse. The requester drops dbg_req in the ack cycle, and any
// dbg_req seen while dbg_ack=1 is ignored. dbg_readdata is valid from the
// ack cycle until the next completed read.
interface mips_dmem_arbiter_if;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;

  logic        dbg_req;
  logic        dbg_write;
  logic [31:0] dbg_address;
  logic [31:0] dbg_writedata;
  logic        dbg_halt;
  logic        dbg_ack;
  logic [31:0] dbg_readdata;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  // Arbiter side
  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata,
    output cpu_readdata,
    input  dbg_req, dbg_write, dbg_address, dbg_writedata, dbg_halt,
    output dbg_ack, dbg_readdata,
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata
  );

  // Requester / memory side
  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata,
    input  cpu_readdata,
    output dbg_req, dbg_write, dbg_address, dbg_writedata, dbg_halt,
    input  dbg_ack, dbg_readdata,
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata
  );
endinterface

// File: rtl/mips_dmem_arbiter.sv
// Shares the single data-memory port between the CPU and a debug port.
// The CPU owns the port by default; debug accesses steal one cycle by
// stalling the CPU through its clock enable, and a halt mode hands the
// port to debug indefinitely.
module mips_dmem_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable_in,
  output logic                 cpu_clk_enable,
  mips_dmem_arbiter_if.slave   bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_DBG  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;

  logic pending;
  logic cpu_busy;
  logic grant;
  logic accept;

  // The stall depends on registered state only, so dbg_* never reaches
  // the CPU clock enable combinationally.
  assign cpu_clk_enable   = clk_enable_in & (state_q == ST_CPU);
  assign bus.cpu_readdata = bus.mem_readdata;
  assign bus.dbg_ack      = dbg_ack_q;
  assign bus.dbg_readdata = dbg_rdata_q;
  assign state_o          = state_q;

  // Next-state, starvation counter and debug completion decode
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    accept     = 1'b0;
    // A request seen in its own ack cycle is the old one being dropped.
    pending    = bus.dbg_req & ~dbg_ack_q;
    cpu_busy   = bus.cpu_read | bus.cpu_write;
    grant      = pending & (~cpu_busy | (wait_cnt_q == WAIT_LAST));

    case (state_q)
      ST_CPU: begin
        if (grant) begin
          state_d    = ST_DBG;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = pending ? wait_cnt_q + WAIT_W'(1) : '0;
          if (bus.dbg_halt) state_d = ST_HALT;
        end
      end
      ST_DBG: begin
        accept     = 1'b1;
        wait_cnt_d = '0;
        state_d    = bus.dbg_halt ? ST_HALT : ST_CPU;
      end
      ST_HALT: begin
        accept     = pending;
        wait_cnt_d = '0;
        if (~bus.dbg_halt & ~pending) state_d = ST_CPU;
      end
      default: begin
        state_d    = ST_CPU;
        wait_cnt_d = '0;
      end
    endcase

    dbg_ack_d   = accept;
    dbg_rdata_d = (accept & ~bus.dbg_write) ? bus.mem_readdata : dbg_rdata_q;
  end

  // Memory port mux; only the owner of the current state can write
  always_comb begin
    bus.mem_address   = bus.cpu_address;
    bus.mem_writedata = bus.cpu_writedata;
    bus.mem_read      = bus.cpu_read;
    bus.mem_write     = bus.cpu_write;
    if (state_q != ST_CPU) begin
      bus.mem_address   = bus.dbg_address;
      bus.mem_writedata = bus.dbg_writedata;
      bus.mem_read      = accept & ~bus.dbg_write;
      bus.mem_write     = accept & bus.dbg_write;
    end
  end

  // State registers; reset aborts any debug access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CPU;
      wait_cnt_q  <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Bench for mips_dmem_arbiter: a behavioural CPU, debug requester and RAM
// around the arbiter, with a golden memory image and a cycle-level model of
// who owns the port, checked each cycle.
module tb_mips_dmem_arbiter;
  localparam int MAX_WAIT = 8;
  localparam int WAIT_W   = 4;

  logic       clk;
  logic       reset;
  logic       clk_enable_in;
  logic       cpu_clk_enable;
  logic [1:0] state_dbg;

  mips_dmem_arbiter_if bus();

  mips_dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable_in (clk_enable_in),
    .cpu_clk_enable(cpu_clk_enable),
    .bus           (bus),
    .state_o       (state_dbg)
  );

  // ---------------- clock / reset / RAM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [16];
  logic        ram_init;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  assign bus.mem_readdata = ram[bus.mem_address[5:2]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    end else if (bus.mem_write) begin
      ram[bus.mem_address[5:2]] <= bus.mem_writedata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int          n_cmp;
  int          n_fail;
  logic [31:0] golden [16];
  logic [31:0] exp_q[$];
  logic [31:0] m_rd;       // last captured debug read
  bit          m_access;   // this cycle is a stolen debug cycle
  bit          m_halted;   // CPU frozen by halt mode this cycle
  int          defer;      // CPU cycles a pending request has been deferred
  bit          cpu_done;   // CPU request of the last cycle was taken

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic reset_model();
    m_access = 1'b0;
    m_halted = 1'b0;
    defer    = 0;
    m_rd     = '0;
    exp_q.delete();
  endtask

  // One clock cycle: inputs are already set; evaluate port ownership before
  // the edge, then check the registered debug outputs just after it.
  task automatic step();
    logic       pending, busy, stall_now, access, was_wr;
    logic [3:0] di, ci;
    @(negedge clk);
    pending   = bus.dbg_req & ~bus.dbg_ack;
    busy      = bus.cpu_read | bus.cpu_write;
    stall_now = m_access | m_halted;
    access    = m_access | (m_halted & pending);
    was_wr    = bus.dbg_write;
    di        = bus.dbg_address[5:2];
    ci        = bus.cpu_address[5:2];
    cpu_done  = 1'b0;
    check_b("cpu_clk_enable", cpu_clk_enable, clk_enable_in & ~stall_now);
    if (!stall_now) begin
      check_b("mem_write_cpu", bus.mem_write, bus.cpu_write);
      check_b("mem_read_cpu", bus.mem_read, bus.cpu_read);
      if (busy) check("mem_address_cpu", bus.mem_address, bus.cpu_address);
      if (bus.cpu_write) check("mem_wdata_cpu", bus.mem_writedata, bus.cpu_writedata);
      if (bus.cpu_read) check("cpu_readdata", bus.cpu_readdata, golden[ci]);
      if (bus.cpu_write) golden[ci] = bus.cpu_writedata;
      cpu_done = clk_enable_in;
      if (pending && (!busy || defer + 1 == MAX_WAIT)) begin
        m_access = 1'b1;
        defer    = 0;
      end else begin
        defer    = pending ? defer + 1 : 0;
        m_halted = bus.dbg_halt;
      end
    end else begin
      if (access) begin
        check("mem_address_dbg", bus.mem_address, bus.dbg_address);
        check_b("mem_write_dbg", bus.mem_write, was_wr);
        check_b("mem_read_dbg", bus.mem_read, ~was_wr);
        if (was_wr) begin
          check("mem_wdata_dbg", bus.mem_writedata, bus.dbg_writedata);
          golden[di] = bus.dbg_writedata;
        end else begin
          exp_q.push_back(golden[di]);
        end
      end else begin
        check_b("halt_idle_write", bus.mem_write, 1'b0);
        check_b("halt_idle_read", bus.mem_read, 1'b0);
      end
      if (m_access) begin
        m_access = 1'b0;
        m_halted = bus.dbg_halt;
      end else begin
        m_halted = bus.dbg_halt | pending;
      end
    end
    @(posedge clk);
    #1;
    check_b("dbg_ack", bus.dbg_ack, access);
    if (access && !was_wr && exp_q.size() > 0) m_rd = exp_q.pop_front();
    check("dbg_readdata", bus.dbg_readdata, m_rd);
  endtask

  // ---------------- driver tasks ----------------
  // A stalled CPU keeps presenting the same request.
  task automatic cpu_drive(input int busy_pct);
    int         r;
    logic [3:0] a;
    if (!cpu_done) return;
    r = $urandom_range(99);
    a = 4'($urandom_range(15));
    bus.cpu_read      = 1'b0;
    bus.cpu_write     = 1'b0;
    bus.cpu_address   = {26'd0, a, 2'b00};
    bus.cpu_writedata = $urandom;
    if (r < busy_pct) begin
      if ($urandom_range(1) == 1) bus.cpu_write = 1'b1;
      else                        bus.cpu_read  = 1'b1;
    end
  endtask

  task automatic cpu_set(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
    bus.cpu_read      = rd;
    bus.cpu_write     = wr;
    bus.cpu_address   = addr;
    bus.cpu_writedata = data;
  endtask

  task automatic dbg_drive(input bit allow_new);
    if (bus.dbg_ack) begin
      bus.dbg_req = 1'b0;
    end else if (!bus.dbg_req && allow_new && $urandom_range(3) == 0) begin
      bus.dbg_write     = 1'($urandom_range(1));
      bus.dbg_address   = {26'd0, 4'($urandom_range(15)), 2'b00};
      bus.dbg_writedata = $urandom;
      bus.dbg_req       = 1'b1;
    end
  endtask

  // Issue one debug access and run until its ack cycle has passed.
  // cycles = clock cycles from raising dbg_req until dbg_ack is seen.
  task automatic dbg_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input int busy_pct, input bit hold_extra, output int cycles);
    bus.dbg_write     = wr;
    bus.dbg_address   = addr;
    bus.dbg_writedata = data;
    bus.dbg_req       = 1'b1;
    cycles = 0;
    do begin
      step();
      cpu_drive(busy_pct);
      cycles++;
    end while (!bus.dbg_ack && cycles < 40);
    check_b("dbg_ack_seen", bus.dbg_ack, 1'b1);
    if (!hold_extra) bus.dbg_req = 1'b0;
    step();
    cpu_drive(busy_pct);
    bus.dbg_req = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc;
    n_cmp  = 0;
    n_fail = 0;
    reset         = 1'b0;
    clk_enable_in = 1'b1;
    ram_init      = 1'b1;
    cpu_set(1'b0, 1'b0, 32'd0, 32'd0);
    bus.dbg_req       = 1'b1;
    bus.dbg_write     = 1'b0;
    bus.dbg_address   = 32'h0;
    bus.dbg_writedata = 32'd0;
    bus.dbg_halt      = 1'b0;
    for (int i = 0; i < 16; i++) golden[i] = init_word(i);
    reset_model();
    cpu_done = 1'b1;

    // Reset held with a debug request already raised
    repeat (3) @(posedge clk);
    #1;
    check_b("rst_dbg_ack", bus.dbg_ack, 1'b0);
    check_b("rst_cpu_clk_en_hi", cpu_clk_enable, 1'b1);
    check("rst_dbg_readdata", bus.dbg_readdata, 32'd0);
    check_b("rst_state_known", $isunknown(state_dbg), 1'b0);
    clk_enable_in = 1'b0;
    #1;
    check_b("rst_cpu_clk_en_lo", cpu_clk_enable, 1'b0);
    clk_enable_in = 1'b1;
    ram_init = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    dbg_access(1'b0, 32'h0, 32'd0, 0, 1'b0, cyc);
    check("rst_release_latency", 32'(cyc), 32'd2);
    check("rst_release_rdata", bus.dbg_readdata, init_word(0));

    // Debug write then read back with the CPU idle
    dbg_access(1'b1, 32'h0, 32'h1234_5678, 0, 1'b0, cyc);
    check("idle_wr_latency", 32'(cyc), 32'd2);
    dbg_access(1'b0, 32'h0, 32'd0, 0, 1'b0, cyc);
    check("idle_rd_latency", 32'(cyc), 32'd2);
    check("idle_rd_data", bus.dbg_readdata, 32'h1234_5678);

    // CPU busy every cycle: the request is forced in after MAX_WAIT cycles
    cpu_set(1'b0, 1'b1, 32'h10, 32'hA5A5_0010);
    dbg_access(1'b0, 32'h14, 32'd0, 100, 1'b0, cyc);
    check("starve_latency", 32'(cyc), 32'(MAX_WAIT + 1));
    repeat (3) begin
      step();
      cpu_drive(0);
    end

    // Program results left in memory, then halt and inspect
    cpu_set(1'b0, 1'b1, 32'h0, 32'h0500_0000);
    step();
    cpu_set(1'b0, 1'b1, 32'h4, 32'h0C00_0000);
    step();
    cpu_set(1'b0, 1'b0, 32'h0, 32'd0);
    bus.dbg_halt = 1'b1;
    repeat (3) step();
    dbg_access(1'b0, 32'h0, 32'd0, 0, 1'b0, cyc);
    check("halt_rd0_latency", 32'(cyc), 32'd1);
    check("halt_rd0_data", bus.dbg_readdata, 32'h0500_0000);
    dbg_access(1'b0, 32'h4, 32'd0, 0, 1'b0, cyc);
    check("halt_rd4_data", bus.dbg_readdata, 32'h0C00_0000);
    repeat (2) step();
    bus.dbg_halt = 1'b0;
    repeat (3) step();
    cpu_done = 1'b1;

    // Reset lands in the middle of a debug write to word 0x8
    bus.dbg_write     = 1'b1;
    bus.dbg_address   = 32'h8;
    bus.dbg_writedata = 32'hDEAD_BEEF;
    bus.dbg_req       = 1'b1;
    step();
    @(negedge clk);
    check_b("rstmid_mem_write_pre", bus.mem_write, 1'b1);
    #1 reset = 1'b0;
    #1;
    check_b("rstmid_mem_write", bus.mem_write, 1'b0);
    check_b("rstmid_cpu_clk_en", cpu_clk_enable, 1'b1);
    bus.dbg_req = 1'b0;
    @(posedge clk);
    #1;
    check_b("rstmid_no_ack", bus.dbg_ack, 1'b0);
    check("rstmid_word8", ram[2], golden[2]);
    reset_model();
    cpu_done = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) step();

    // Request held into the ack cycle must not start a second access
    dbg_access(1'b0, 32'h8, 32'd0, 0, 1'b1, cyc);
    check("hold_rd_data", bus.dbg_readdata, golden[2]);
    repeat (3) step();

    // Randomized traffic, light then heavy CPU load
    for (int n = 0; n < 600; n++) begin
      step();
      cpu_drive(n < 300 ? 50 : 95);
      dbg_drive(1'b1);
    end
    repeat (20) begin
      step();
      cpu_drive(0);
      dbg_drive(1'b0);
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("final_mem[%0d]", i), ram[i], golden[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
